// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit_pkg
//  Description : Shared encodings for the hazard stall unit: FSM states,
//                branch types, the shadow-slot record and writer/match helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_unit_pkg;

    // FSM state encoding
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_STALL = 1'b1;

    // Branch type encoding of the ID instruction
    localparam logic [1:0] c_BR_NONE  = 2'b00;
    localparam logic [1:0] c_BR_BEQ   = 2'b01;
    localparam logic [1:0] c_BR_BNE   = 2'b10;
    localparam logic [1:0] c_BR_OTHER = 2'b11;

    // One shadow-pipeline slot: {valid, RegWrite, MemRead, Rd}
    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memRead;
        logic [4:0] rd;
    } hazard_slot_t;

    // A slot produces a value only if it is real, writes, and does not target $0
    function automatic logic isWriter(input hazard_slot_t s);
        return s.valid & s.regWrite & (s.rd != 5'd0);
    endfunction

    // One match signal per slot, so Rs and Rt hitting the same Rd stall once
    function automatic logic rdMatches(input hazard_slot_t s,
                                       input logic [4:0]   rs,
                                       input logic [4:0]   rt);
        return (s.rd == rs) | (s.rd == rt);
    endfunction

endpackage : hazard_stall_unit_pkg
`default_nettype wire

// File: rtl/hazard_slot_reg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_slot_reg
//  Description : One shadow-pipeline slot register with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_slot_reg
    import hazard_stall_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  hazard_slot_t i_d,
    output hazard_slot_t o_q
);

    hazard_slot_t r_q;

    // Load the slot every cycle; clear marks it empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : hazard_slot_reg
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : ID-stage hazard detector. Tracks the EX and MEM instructions
//                in a two-slot shadow pipeline and stalls branches that need
//                an operand still in flight, plus classic load-use hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Branch,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic [4:0]       ID_RegisterRd,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCount
);

    hazard_slot_t     w_idSlot;
    hazard_slot_t     w_exNext;
    hazard_slot_t     w_exSlot;
    hazard_slot_t     w_memSlot;
    logic             w_isBranch;
    logic             w_exHit;
    logic             w_memHit;
    logic             w_stall;
    logic [0:0]       r_state;
    logic [0:0]       w_nextState;
    logic [CNT_W-1:0] r_stallCount;

    // ID instruction as it would enter EX; a stall injects an empty slot instead
    assign w_idSlot = '{valid: 1'b1, regWrite: ID_RegWrite,
                        memRead: ID_MemRead, rd: ID_RegisterRd};
    assign w_exNext = w_stall ? hazard_slot_t'('0) : w_idSlot;

    hazard_slot_reg u_exSlot (
        .clk (clk),
        .rst (reset),
        .i_d (w_exNext),
        .o_q (w_exSlot)
    );

    hazard_slot_reg u_memSlot (
        .clk (clk),
        .rst (reset),
        .i_d (w_exSlot),
        .o_q (w_memSlot)
    );

    assign w_isBranch = (Branch != c_BR_NONE);
    assign w_exHit    = isWriter(w_exSlot)
                      & rdMatches(w_exSlot, IF_ID_RegisterRs, IF_ID_RegisterRt);
    assign w_memHit   = isWriter(w_memSlot) & w_memSlot.memRead
                      & rdMatches(w_memSlot, IF_ID_RegisterRs, IF_ID_RegisterRt);

    // Branches resolve in ID so they wait on any EX producer and on a load in
    // MEM; other instructions only wait on a load in EX. Held off under reset
    // so the pipe is released while the slots are being cleared.
    assign w_stall = ~reset & ((w_isBranch & (w_exHit | w_memHit))
                             | (~w_isBranch & w_exHit & w_exSlot.memRead));

    assign PCWrite      = ~w_stall;
    assign IF_ID_Write  = ~w_stall;
    assign ID_EX_Bubble = w_stall;
    assign IF_ID_Flush  = w_isBranch & BranchTaken & ~w_stall;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state: follow the combinational stall request
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_RUN:   if (w_stall)  w_nextState = c_ST_STALL;
            c_ST_STALL: if (!w_stall) w_nextState = c_ST_RUN;
            default:    w_nextState = c_ST_RUN;
        endcase
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != {CNT_W{1'b1}})) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign Stalled    = (r_state == c_ST_STALL);
    assign StallCount = r_stallCount;

endmodule : hazard_stall_unit
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Directed bench for hazard_stall_unit. A 16-bit and a 4-bit
//                counter instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Branch;
    logic [4:0]  Rs, Rt, Rd;
    logic        RegWrite, MemRead, Taken;

    logic        pcw, ifidw, bub, flush, stalled;
    logic [15:0] cnt;
    logic        pcwS, ifidwS, bubS, flushS, stalledS;
    logic [3:0]  cntS;

    typedef struct {
        string tag;
        logic  pcw;
        logic  flush;
        logic  stalled;
        int    cnt;
    } exp_t;

    exp_t q[$];
    int   nVec = 0;
    int   nMis = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .Branch(Branch),
        .IF_ID_RegisterRs(Rs), .IF_ID_RegisterRt(Rt),
        .ID_RegWrite(RegWrite), .ID_MemRead(MemRead), .ID_RegisterRd(Rd),
        .BranchTaken(Taken),
        .PCWrite(pcw), .IF_ID_Write(ifidw), .ID_EX_Bubble(bub),
        .IF_ID_Flush(flush), .Stalled(stalled), .StallCount(cnt)
    );

    hazard_stall_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .Branch(Branch),
        .IF_ID_RegisterRs(Rs), .IF_ID_RegisterRt(Rt),
        .ID_RegWrite(RegWrite), .ID_MemRead(MemRead), .ID_RegisterRd(Rd),
        .BranchTaken(Taken),
        .PCWrite(pcwS), .IF_ID_Write(ifidwS), .ID_EX_Bubble(bubS),
        .IF_ID_Flush(flushS), .Stalled(stalledS), .StallCount(cntS)
    );

    task automatic chk(input string tag, input string what,
                       input logic [15:0] obs, input logic [15:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    // One ID cycle: drive at the falling edge, queue what the outputs must be,
    // then pop and compare once the combinational paths have settled.
    task automatic cyc(input string tag, input logic rst, input logic [1:0] br,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic rw, input logic mr, input logic [4:0] rd,
                       input logic tk, input logic ePcw, input logic eFlush,
                       input logic eStalled, input int eCnt);
        exp_t e;
        @(negedge clk);
        reset = rst; Branch = br; Rs = rs; Rt = rt;
        RegWrite = rw; MemRead = mr; Rd = rd; Taken = tk;
        q.push_back('{tag: tag, pcw: ePcw, flush: eFlush, stalled: eStalled, cnt: eCnt});
        #1;
        e = q.pop_front();
        chk(e.tag, "PCWrite",      {15'd0, pcw},     {15'd0, e.pcw});
        chk(e.tag, "IF_ID_Write",  {15'd0, ifidw},   {15'd0, e.pcw});
        chk(e.tag, "ID_EX_Bubble", {15'd0, bub},     {15'd0, ~e.pcw});
        chk(e.tag, "IF_ID_Flush",  {15'd0, flush},   {15'd0, e.flush});
        chk(e.tag, "Stalled",      {15'd0, stalled}, {15'd0, e.stalled});
        chk(e.tag, "StallCount",   cnt,              16'(e.cnt));
        chk(e.tag, "StallCount4",  {12'd0, cntS},    16'((e.cnt > 15) ? 15 : e.cnt));
        chk(e.tag, "PCWrite4",     {15'd0, pcwS},    {15'd0, e.pcw});
    endtask

    initial begin
        reset = 1'b1; Branch = 2'b00; Rs = '0; Rt = '0;
        RegWrite = 1'b0; MemRead = 1'b0; Rd = '0; Taken = 1'b0;

        //   tag          rst br     rs  rt  rw mr rd  tk  pcw fl st cnt
        // Reset state
        cyc("rst",        1, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 0);
        cyc("rst_tk",     1, 2'b01,  3,  4,  0, 0, 0,  1,  1,  1, 0, 0);
        // ALU producer then beq: one stall cycle
        cyc("alu_add",    0, 2'b00,  0,  0,  1, 0, 1,  0,  1,  0, 0, 0);
        cyc("alu_beq0",   0, 2'b01,  1,  0,  0, 0, 0,  0,  0,  0, 0, 0);
        cyc("alu_beq1",   0, 2'b01,  1,  0,  0, 0, 0,  0,  1,  0, 1, 1);
        cyc("alu_nop",    0, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 1);
        // Load producer then bne: two stall cycles
        cyc("ld_lw",      0, 2'b00,  0,  0,  1, 1, 2,  0,  1,  0, 0, 1);
        cyc("ld_bne0",    0, 2'b10,  3,  2,  0, 0, 0,  0,  0,  0, 0, 1);
        cyc("ld_bne1",    0, 2'b10,  3,  2,  0, 0, 0,  0,  0,  0, 1, 2);
        cyc("ld_bne2",    0, 2'b10,  3,  2,  0, 0, 0,  0,  1,  0, 1, 3);
        cyc("ld_nop",     0, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 3);
        // Register 0 never stalls
        cyc("r0_add",     0, 2'b00,  0,  0,  1, 0, 0,  0,  1,  0, 0, 3);
        cyc("r0_beq",     0, 2'b01,  0,  0,  0, 0, 0,  0,  1,  0, 0, 3);
        cyc("r0_lw",      0, 2'b00,  0,  0,  1, 1, 0,  0,  1,  0, 0, 3);
        cyc("r0_beq2",    0, 2'b01,  0,  0,  0, 0, 0,  0,  1,  0, 0, 3);
        cyc("r0_beq3",    0, 2'b01,  0,  0,  0, 0, 0,  0,  1,  0, 0, 3);
        // Taken branch without a hazard flushes for one cycle
        cyc("tk_beq",     0, 2'b01,  5,  6,  0, 0, 0,  1,  1,  1, 0, 3);
        cyc("tk_nop",     0, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 3);
        // Taken branch behind a hazard: no flush until the stall clears
        cyc("tkh_add",    0, 2'b00,  0,  0,  1, 0, 7,  0,  1,  0, 0, 3);
        cyc("tkh_beq0",   0, 2'b01,  7,  1,  0, 0, 0,  1,  0,  0, 0, 3);
        cyc("tkh_beq1",   0, 2'b01,  7,  1,  0, 0, 0,  1,  1,  1, 1, 4);
        cyc("tkh_nop",    0, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 4);
        // Rs and Rt both hit the same writer: still a single stall cycle
        cyc("dbl_add",    0, 2'b00,  0,  0,  1, 0, 8,  0,  1,  0, 0, 4);
        cyc("dbl_beq0",   0, 2'b01,  8,  8,  0, 0, 0,  0,  0,  0, 0, 4);
        cyc("dbl_beq1",   0, 2'b01,  8,  8,  0, 0, 0,  0,  1,  0, 1, 5);
        cyc("dbl_nop",    0, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 5);
        // Load-use on a non-branch instruction
        cyc("lu_lw",      0, 2'b00,  0,  0,  1, 1, 9,  0,  1,  0, 0, 5);
        cyc("lu_add0",    0, 2'b00,  9,  4,  1, 0, 10, 0,  0,  0, 0, 5);
        cyc("lu_add1",    0, 2'b00,  9,  4,  1, 0, 10, 0,  1,  0, 1, 6);
        cyc("lu_nop",     0, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 6);

        // Saturation: repeated load-branch pairs give 2 stall cycles each;
        // the 4-bit instance must stop at 15 while the 16-bit one keeps counting.
        for (int r = 0; r < 8; r++) begin
            cyc("sat_lw",   0, 2'b00,  0,  0,  1, 1, 2,  0,  1,  0, 0, 6 + 2*r);
            cyc("sat_bne0", 0, 2'b10,  2,  3,  0, 0, 0,  0,  0,  0, 0, 6 + 2*r);
            cyc("sat_bne1", 0, 2'b10,  2,  3,  0, 0, 0,  0,  0,  0, 1, 7 + 2*r);
            cyc("sat_bne2", 0, 2'b10,  2,  3,  0, 0, 0,  0,  1,  0, 1, 8 + 2*r);
        end

        // Reset in the second cycle of a load-branch stall
        cyc("rs_lw",      0, 2'b00,  0,  0,  1, 1, 2,  0,  1,  0, 0, 22);
        cyc("rs_bne0",    0, 2'b10,  3,  2,  0, 0, 0,  0,  0,  0, 0, 22);
        cyc("rs_bne1",    1, 2'b10,  3,  2,  0, 0, 0,  0,  1,  0, 1, 23);
        cyc("rs_after",   0, 2'b10,  3,  2,  0, 0, 0,  0,  1,  0, 0, 0);
        cyc("rs_nop",     0, 2'b00,  0,  0,  0, 0, 0,  0,  1,  0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule : tb_hazard_stall_unit
`default_nettype wire
